// File: rtl/dcache_ctrl_2way.sv
// ============================================================================
// Module   : dcache_ctrl_2way
// Purpose  : Request controller for a 2-way set-associative data cache.
//            Handles hit compare/update, dirty-victim write-back and line refill.
//            Optional hit/miss counters are enabled by defining DCACHE_CTRL_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl_2way #(
  parameter int TAG_W  = 9,
  parameter int IDX_W  = 5,
  parameter int OFF_W  = 2,
  parameter int WORD_W = 16,
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W,
  localparam int LA_W   = TAG_W + IDX_W,
  localparam int LINE_W = WORD_W << OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  output logic [LA_W-1:0]   c_addr,
  output logic              c_re,
  output logic              c_we,
  output logic [LINE_W-1:0] c_wr_data,
  output logic              c_wdirty,
  output logic              c_toggle,
  input  logic [LINE_W-1:0] c_rd_data,
  input  logic [TAG_W-1:0]  c_tag_out,
  input  logic              c_hit,
  input  logic              c_dirty,
  output logic [LA_W-1:0]   m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_rdy
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int NWORDS = 1 << OFF_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WR_HIT    = 3'd2,
    S_WRITEBACK = 3'd3,
    S_ALLOCATE  = 3'd4,
    S_INSTALL   = 3'd5,
    S_RESP      = 3'd6
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   wdata_q;
  logic                wr_q;
  logic [LINE_W-1:0]   line_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                cpu_ready_q;
  logic [LA_W-1:0]     c_addr_q;
  logic                c_re_q;
  logic                c_we_q;
  logic                c_wdirty_q;
  logic                c_toggle_q;
  logic [LA_W-1:0]     m_addr_q;
  logic                m_re_q;
  logic                m_we_q;
  logic [LINE_W-1:0]   m_wdata_q;

  logic [OFF_W-1:0]    w_off;
  logic [IDX_W-1:0]    w_idx;

  assign w_off = addr_q[OFF_W-1:0];
  assign w_idx = addr_q[OFF_W +: IDX_W];

  function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                 input logic [OFF_W-1:0]  off);
    sel_word = '0;
    for (int w = 0; w < NWORDS; w++)
      if (off == OFF_W'(w)) sel_word = line[w*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [WORD_W-1:0] word);
    merge_word = line;
    for (int w = 0; w < NWORDS; w++)
      if (off == OFF_W'(w)) merge_word[w*WORD_W +: WORD_W] = word;
  endfunction

  // Every output is a register loaded on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      line_q      <= '0;
      rdata_q     <= '0;
      cpu_ready_q <= 1'b0;
      c_addr_q    <= '0;
      c_re_q      <= 1'b0;
      c_we_q      <= 1'b0;
      c_wdirty_q  <= 1'b0;
      c_toggle_q  <= 1'b0;
      m_addr_q    <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_wdata_q   <= '0;
    end else begin
      cpu_ready_q <= 1'b0;
      c_re_q      <= 1'b0;
      c_we_q      <= 1'b0;
      c_wdirty_q  <= 1'b0;
      c_toggle_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cpu_re || cpu_we) begin
            addr_q   <= cpu_addr;
            wdata_q  <= cpu_wdata;
            wr_q     <= cpu_we;
            c_addr_q <= cpu_addr[ADDR_W-1:OFF_W];
            c_re_q   <= 1'b1;
            state_q  <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (c_hit) begin
            if (wr_q) begin
              line_q     <= merge_word(c_rd_data, w_off, wdata_q);
              c_we_q     <= 1'b1;
              c_wdirty_q <= 1'b1;
              state_q    <= S_WR_HIT;
            end else begin
              rdata_q     <= sel_word(c_rd_data, w_off);
              cpu_ready_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else if (c_dirty) begin
            m_we_q    <= 1'b1;
            m_addr_q  <= {c_tag_out, w_idx};
            m_wdata_q <= c_rd_data;
            state_q   <= S_WRITEBACK;
          end else begin
            m_re_q   <= 1'b1;
            m_addr_q <= addr_q[ADDR_W-1:OFF_W];
            state_q  <= S_ALLOCATE;
          end
        end
        S_WR_HIT: begin
          cpu_ready_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_WRITEBACK: begin
          if (m_rdy) begin
            m_we_q   <= 1'b0;
            m_re_q   <= 1'b1;
            m_addr_q <= addr_q[ADDR_W-1:OFF_W];
            state_q  <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (m_rdy) begin
            m_re_q     <= 1'b0;
            line_q     <= wr_q ? merge_word(m_rdata, w_off, wdata_q) : m_rdata;
            c_we_q     <= 1'b1;
            c_wdirty_q <= wr_q;
            c_toggle_q <= 1'b1;
            state_q    <= S_INSTALL;
          end
        end
        S_INSTALL: begin
          if (!wr_q) rdata_q <= sel_word(line_q, w_off);
          cpu_ready_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Stall must rise in the same cycle the request appears, so it is decoded here.
  assign cpu_stall = (state_q == S_IDLE) ? (cpu_re | cpu_we) : (state_q != S_RESP);

  assign cpu_rdata = rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign c_addr    = c_addr_q;
  assign c_re      = c_re_q;
  assign c_we      = c_we_q;
  assign c_wr_data = line_q;
  assign c_wdirty  = c_wdirty_q;
  assign c_toggle  = c_toggle_q;
  assign m_addr    = m_addr_q;
  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign m_wdata   = m_wdata_q;

`ifdef DCACHE_CTRL_PERF_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == S_COMPARE) begin
      if (c_hit) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl_2way.sv
// ============================================================================
// Module   : tb_dcache_ctrl_2way
// Purpose  : Directed self-checking bench for dcache_ctrl_2way.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ctrl_2way;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_stall;
  logic [13:0] c_addr;
  logic        c_re;
  logic        c_we;
  logic [63:0] c_wr_data;
  logic        c_wdirty;
  logic        c_toggle;
  logic [63:0] c_rd_data;
  logic [8:0]  c_tag_out;
  logic        c_hit;
  logic        c_dirty;
  logic [13:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_rdy;
`ifdef DCACHE_CTRL_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dcache_ctrl_2way dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_stall (cpu_stall),
    .c_addr    (c_addr),
    .c_re      (c_re),
    .c_we      (c_we),
    .c_wr_data (c_wr_data),
    .c_wdirty  (c_wdirty),
    .c_toggle  (c_toggle),
    .c_rd_data (c_rd_data),
    .c_tag_out (c_tag_out),
    .c_hit     (c_hit),
    .c_dirty   (c_dirty),
    .m_addr    (m_addr),
    .m_re      (m_re),
    .m_we      (m_we),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_rdy     (m_rdy)
`ifdef DCACHE_CTRL_PERF_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
    c_rd_data = '0; c_tag_out = '0; c_hit = 1'b0; c_dirty = 1'b0;
    m_rdata = '0; m_rdy = 1'b0;
    tick(); tick();
    chk("rst_ready", {63'd0, cpu_ready}, 64'd0);
    chk("rst_stall", {63'd0, cpu_stall}, 64'd0);
    chk("rst_cre",   {63'd0, c_re}, 64'd0);
    chk("rst_cwe",   {63'd0, c_we}, 64'd0);
    chk("rst_mrw",   {62'd0, m_re, m_we}, 64'd0);
    chk("rst_rdata", {48'd0, cpu_rdata}, 64'd0);
    rst = 1'b0;

    // Stray m_rdy while idle must be ignored.
    m_rdy = 1'b1;
    tick();
    m_rdy = 1'b0;
    chk("idle_mrdy_mre",   {63'd0, m_re}, 64'd0);
    chk("idle_mrdy_stall", {63'd0, cpu_stall}, 64'd0);

    // Cold read 0x0104, clean miss, memory latency 4.
    cpu_addr = 16'h0104; cpu_re = 1'b1; c_hit = 1'b0; c_dirty = 1'b0;
    #1;
    chk("cold_stall_idle", {63'd0, cpu_stall}, 64'd1);
    tick();
    chk("cold_cre",   {63'd0, c_re}, 64'd1);
    chk("cold_caddr", {50'd0, c_addr}, 64'h0041);
    tick();
    m_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
    for (int i = 0; i < 4; i++) begin
      m_rdy = (i == 3);
      chk("cold_mre",   {63'd0, m_re}, 64'd1);
      chk("cold_mwe",   {63'd0, m_we}, 64'd0);
      chk("cold_maddr", {50'd0, m_addr}, 64'h0041);
      chk("cold_stall", {63'd0, cpu_stall}, 64'd1);
      tick();
    end
    m_rdy = 1'b0;
    chk("cold_inst_cwe",  {63'd0, c_we}, 64'd1);
    chk("cold_inst_data", c_wr_data, 64'hDDDD_CCCC_BBBB_AAAA);
    chk("cold_inst_tog",  {63'd0, c_toggle}, 64'd1);
    chk("cold_inst_dirty", {63'd0, c_wdirty}, 64'd0);
    chk("cold_inst_mre",  {63'd0, m_re}, 64'd0);
    tick();
    cpu_re = 1'b0;
    chk("cold_ready", {63'd0, cpu_ready}, 64'd1);
    chk("cold_rdata", {48'd0, cpu_rdata}, 64'h0000_0000_0000_AAAA);
    chk("cold_resp_stall", {63'd0, cpu_stall}, 64'd0);
    tick();
    chk("cold_ready_drop", {63'd0, cpu_ready}, 64'd0);

    // Read hit 0x0107: ready in the second cycle after the accepting edge.
    cpu_addr = 16'h0107; cpu_re = 1'b1; c_hit = 1'b1;
    c_rd_data = 64'h4444_3333_2222_1111;
    tick();
    chk("rhit_cre",   {63'd0, c_re}, 64'd1);
    chk("rhit_caddr", {50'd0, c_addr}, 64'h0041);
    chk("rhit_early", {63'd0, cpu_ready}, 64'd0);
    tick();
    cpu_re = 1'b0;
    chk("rhit_ready", {63'd0, cpu_ready}, 64'd1);
    chk("rhit_rdata", {48'd0, cpu_rdata}, 64'h4444);
    chk("rhit_mem",   {62'd0, m_re, m_we}, 64'd0);
    tick();

    // Write hit 0x0105 with BEEF.
    cpu_addr = 16'h0105; cpu_we = 1'b1; cpu_wdata = 16'hBEEF;
    tick();
    chk("whit_cre", {63'd0, c_re}, 64'd1);
    tick();
    chk("whit_cwe",   {63'd0, c_we}, 64'd1);
    chk("whit_cre_off", {63'd0, c_re}, 64'd0);
    chk("whit_data",  c_wr_data, 64'h4444_3333_BEEF_1111);
    chk("whit_dirty", {63'd0, c_wdirty}, 64'd1);
    chk("whit_tog",   {63'd0, c_toggle}, 64'd0);
    chk("whit_caddr", {50'd0, c_addr}, 64'h0041);
    tick();
    cpu_we = 1'b0;
    chk("whit_ready",  {63'd0, cpu_ready}, 64'd1);
    chk("whit_cwe_1cy", {63'd0, c_we}, 64'd0);
    chk("whit_rdata_hold", {48'd0, cpu_rdata}, 64'h4444);
    tick();

    // Dirty write miss 0x080E (index 3, offset 2), victim tag 0x1A5, latency 2.
    cpu_addr = 16'h080E; cpu_we = 1'b1; cpu_wdata = 16'h1234;
    c_hit = 1'b0; c_dirty = 1'b1; c_tag_out = 9'h1A5;
    c_rd_data = 64'hCAFE_F00D_DEAD_BEEF;
    tick();
    chk("dm_caddr", {50'd0, c_addr}, 64'h0203);
    tick();
    c_dirty = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_rdy = (i == 1);
      chk("dm_wb_mwe",   {63'd0, m_we}, 64'd1);
      chk("dm_wb_mre",   {63'd0, m_re}, 64'd0);
      chk("dm_wb_maddr", {50'd0, m_addr}, 64'h34A3);
      chk("dm_wb_wdata", m_wdata, 64'hCAFE_F00D_DEAD_BEEF);
      tick();
    end
    m_rdata = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 2; i++) begin
      m_rdy = (i == 1);
      chk("dm_al_mre",   {63'd0, m_re}, 64'd1);
      chk("dm_al_mwe",   {63'd0, m_we}, 64'd0);
      chk("dm_al_maddr", {50'd0, m_addr}, 64'h0203);
      tick();
    end
    m_rdy = 1'b0;
    chk("dm_inst_cwe",   {63'd0, c_we}, 64'd1);
    chk("dm_inst_data",  c_wr_data, 64'h1111_1234_3333_4444);
    chk("dm_inst_dirty", {63'd0, c_wdirty}, 64'd1);
    chk("dm_inst_tog",   {63'd0, c_toggle}, 64'd1);
    tick();
    cpu_we = 1'b0;
    chk("dm_ready", {63'd0, cpu_ready}, 64'd1);
    chk("dm_rdata_hold", {48'd0, cpu_rdata}, 64'h4444);
    tick();

    // Reset in the middle of a refill abandons it.
    cpu_addr = 16'h0200; cpu_re = 1'b1; c_hit = 1'b0; c_dirty = 1'b0;
    tick();
    tick();
    chk("ra_mre", {63'd0, m_re}, 64'd1);
    tick();
    rst = 1'b1; cpu_re = 1'b0;
    tick();
    rst = 1'b0;
    chk("ra_mre_drop", {63'd0, m_re}, 64'd0);
    chk("ra_stall",    {63'd0, cpu_stall}, 64'd0);
    chk("ra_cwe",      {63'd0, c_we}, 64'd0);
    chk("ra_rdata",    {48'd0, cpu_rdata}, 64'd0);
    tick();
    chk("ra_no_install", {63'd0, c_we}, 64'd0);

    // Same request again behaves as a cold miss, memory latency 1.
    cpu_re = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    chk("rc_cre", {63'd0, c_re}, 64'd1);
    tick();
    m_rdy = 1'b1;
    chk("rc_mre",   {63'd0, m_re}, 64'd1);
    chk("rc_maddr", {50'd0, m_addr}, 64'h0080);
    tick();
    m_rdy = 1'b0;
    chk("rc_inst_tog", {63'd0, c_toggle}, 64'd1);
    tick();
    cpu_re = 1'b0;
    chk("rc_ready", {63'd0, cpu_ready}, 64'd1);
    chk("rc_rdata", {48'd0, cpu_rdata}, 64'hCDEF);
`ifdef DCACHE_CTRL_PERF_EN
    chk("perf_hit",  {48'd0, hit_cnt}, 64'd0);
    chk("perf_miss", {48'd0, miss_cnt}, 64'd1);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
